instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch unit that reads the instruction memory. It holds the program counter and drives the word address to the combinational instruction memory. Each returned word is captured with its PC into a small in-order buffer, which presents instructions to decode over a valid/ready handshake. It also accepts branch/jump redirects and flags misaligned targets, which the memory would otherwise silently answer with zero.

## Interface
- RESET_PC, 32'd0, PC loaded on reset; must be a multiple of 4
- DEPTH, 2, buffer entries; power of two, ≥ 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_addr  out  32  byte address to instruction memory (its sel input); equals PC register
- imem_data  in  32  word returned combinationally by instruction memory for imem_addr, same cycle
- instr_valid  out  1  buffer head holds an instruction
- instr_ready  in  1  decode accepts head this cycle
- instr_data  out  32  instruction word at buffer head
- instr_pc  out  32  address the head word was fetched from
- redirect_valid  in  1  load new PC (taken branch/jump) this cycle
- redirect_pc  in  32  redirect target address
- fetch_fault  out  1  sticky: fetch halted on misaligned PC

## Operation
- State: pc (32), circular buffer of DEPTH × {pc, word}, read/write pointers, count (log2(DEPTH)+1 bits), fault flag.
- Reset (async, immediate): pc = RESET_PC, buffer empty, fault = 0. Outputs: imem_addr = RESET_PC, instr_valid = 0, instr_data = 0, instr_pc = 0, fetch_fault = 0.
- imem_addr = pc, combinational from register only; it must not depend on any input.
- pop = instr_valid & instr_ready & ~redirect_valid.
- push = ~fault & ~redirect_valid & (count < DEPTH | pop).
- On push: write {pc, imem_data} at tail; pc <= pc + 4, mod 2^32 (0xFFFFFFFC wraps to 0).
- No push (full and no pop, or fault): pc holds, no memory word is lost or duplicated.
- Simultaneous push and pop with the buffer full: both happen, count unchanged.
- instr_valid = (count != 0) & ~redirect_valid. instr_data/instr_pc show the head entry, or 0 when empty.
- Redirect has priority over everything else. At the edge: buffer flushed (count = 0), any handshake that cycle is void, pc <= redirect_pc.
  - redirect_pc[1:0] == 0: fault <= 0.
  - otherwise: fault <= 1.
- While fault = 1: no pushes; pc and imem_addr hold the misaligned value. Only an aligned redirect or rst clears it.
- instr_ready is ignored when instr_valid = 0.

## Timing
- Fetch-to-output latency 1 cycle. The word addressed in cycle N appears at the buffer head in cycle N+1 if the buffer was empty.
- After rst release: first push at the first edge; instr_valid = 1 from the following cycle. Sustained rate is 1 instruction/cycle with instr_ready held high.
- Redirect sampled at edge N:
  - cycle N+1: imem_addr = target, instr_valid = 0;
  - cycle N+2: instr_valid = 1 with instr_pc = target.
  - Redirect bubble is 1 cycle.
- Backpressure: after DEPTH cycles with instr_ready = 0 and the buffer filling, imem_addr freezes. The head entry stays stable until accepted.
- fetch_fault rises the cycle after a misaligned redirect edge. It falls the cycle after an aligned redirect edge.
- rst asserted mid-operation clears everything immediately, without waiting for a clock edge. Any in-flight push is discarded.

## Test plan
- Stream: RESET_PC = 0, memory model returns addr ^ 32'hA5A50000, instr_ready = 1 -> from cycle 1, instr_pc = 0, 4, 8, 12 on consecutive cycles; instr_data = 32'hA5A50000, 32'hA5A50004, … with no gaps.
- Backpressure: instr_ready = 0 for 5 cycles from reset, then 1 -> count saturates at 2, imem_addr holds 8, head stays pc = 0; on release the stream is 0, 4, 8, 12 with no drop or duplicate.
- Redirect with full buffer: buffer holds pc 0, 4; redirect_pc = 0x30 with instr_ready = 1 -> that cycle instr_valid = 0 and no pop is counted; next cycle valid = 0; then instr_pc = 0x30, 0x34.
- Misaligned: redirect_pc = 0x22 -> fetch_fault = 1, instr_valid stays 0, imem_addr = 0x22 held for 10 cycles. Then redirect_pc = 0x10 -> fault clears, stream 0x10, 0x14.
- Wrap: redirect_pc = 0xFFFFFFF8 -> instr_pc = 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Async reset: assert rst between edges while streaming -> instr_valid = 0, imem_addr = RESET_PC, fetch_fault = 0 before the next edge; stream restarts from RESET_PC after release.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction memory port, decode handshake and redirect/fault.
// The master modport is the fetch unit; the slave is memory plus decode.
interface instruction_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    modport master (
        output imem_addr,
        input  imem_data,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        input  redirect_valid,
        input  redirect_pc,
        output fetch_fault
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        output redirect_valid,
        output redirect_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC register driving a combinational imem, an in-order {pc, word}
// buffer towards decode, branch/jump redirect with a sticky misaligned-target fault.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    instruction_fetch_if.master   bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t          fifo [DEPTH];
    logic [31:0]     pc;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            fault;
    logic            empty;
    logic            pop;
    logic            push;

    // A redirect voids any handshake; a pop frees a slot for a same-cycle push.
    always_comb begin
        empty = (count == '0);
        pop   = ~empty & bus.instr_ready & ~bus.redirect_valid;
        push  = ~fault & ~bus.redirect_valid & ((count < FULL) | pop);
    end

    assign bus.imem_addr   = pc;
    assign bus.instr_valid = ~empty & ~bus.redirect_valid;
    assign bus.instr_pc    = empty ? 32'd0 : fifo[rd_ptr].pc;
    assign bus.instr_data  = empty ? 32'd0 : fifo[rd_ptr].word;
    assign bus.fetch_fault = fault;

    // Control state: PC, pointers, occupancy and fault flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            fault  <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc     <= bus.redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            fault  <= (bus.redirect_pc[1:0] != 2'b00);
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset: it is only visible while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= '{pc: pc, word: bus.imem_data};
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, checked against a
// queue-based reference model of the fetch buffer and an XOR-pattern instruction memory.
module tb_instruction_fetch;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] KEY = 32'hA5A50000;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;

    int checks;
    int errors;

    logic [31:0] m_pc;
    logic        m_fault;
    logic [63:0] q[$];

    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.imem_data      = bus.imem_addr ^ KEY;
    assign bus.instr_ready    = rdy;
    assign bus.redirect_valid = rv;
    assign bus.redirect_pc    = rpc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [97:0] obs();
        return {bus.instr_valid, bus.fetch_fault, bus.imem_addr, bus.instr_pc, bus.instr_data};
    endfunction

    function automatic logic [97:0] expv();
        logic [63:0] h;
        logic        v;
        v = (q.size() != 0) && !rv;
        h = (q.size() != 0) ? q[0] : 64'd0;
        return {v, m_fault, m_pc, h[63:32], h[31:0]};
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc    = RESET_PC;
        m_fault = 1'b0;
    endtask

    // Reference behaviour at a clock edge, from the currently applied inputs.
    task automatic model_edge();
        int  n;
        logic p;
        if (rv) begin
            q.delete();
            m_pc    = rpc;
            m_fault = (rpc[1:0] != 2'b00);
        end else begin
            n = q.size();
            p = (n != 0) && rdy;
            if (p) void'(q.pop_front());
            if (!m_fault && (n < int'(DEPTH) || p)) begin
                q.push_back({m_pc, m_pc ^ KEY});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Called just after a falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic r, input logic v, input logic [31:0] t);
        rdy = r;
        rv  = v;
        rpc = t;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'd0);
        checks++;
        if (obs() !== {1'b0, 1'b0, RESET_PC, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset: got %h want %h", obs(), {1'b0, 1'b0, RESET_PC, 32'd0, 32'd0});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL stream cyc %0d: got %h want %h", i, obs(), expv());
            end
            if (i >= 1) begin
                checks++;
                if ({bus.instr_valid, bus.instr_pc, bus.instr_data} !==
                    {1'b1, 32'(4 * (i - 1)), KEY | 32'(4 * (i - 1))}) begin
                    errors++;
                    $display("FAIL stream_seq cyc %0d: got pc %h data %h want pc %h", i,
                             bus.instr_pc, bus.instr_data, 32'(4 * (i - 1)));
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'd0);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL backpressure hold %0d: got %h want %h", i, obs(), expv());
            end
            advance();
        end
        drive(1'b1, 1'b0, 32'd0);
        checks++;
        if ({bus.imem_addr, bus.instr_pc} !== {32'd8, 32'd0}) begin
            errors++;
            $display("FAIL backpressure freeze: got addr %h pc %h want addr 8 pc 0",
                     bus.imem_addr, bus.instr_pc);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            checks++;
            if ({bus.instr_valid, bus.instr_pc} !== {1'b1, 32'(4 * i)}) begin
                errors++;
                $display("FAIL backpressure release %0d: got pc %h want %h", i, bus.instr_pc,
                         32'(4 * i));
            end
            advance();
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'd0);
            advance();
        end
        drive(1'b1, 1'b1, 32'h30);
        checks++;
        if ({bus.instr_valid, bus.instr_pc} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL redirect_void: got valid %b pc %h want valid 0 pc 0",
                     bus.instr_valid, bus.instr_pc);
        end
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL redirect_full cyc %0d: got %h want %h", i, obs(), expv());
            end
            advance();
        end
    endtask

    task automatic test_misaligned();
        drive(1'b1, 1'b1, 32'h22);
        advance();
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b0, 32'd0);
            checks++;
            if ({bus.fetch_fault, bus.instr_valid, bus.imem_addr} !== {1'b1, 1'b0, 32'h22}) begin
                errors++;
                $display("FAIL misaligned hold %0d: got fault %b valid %b addr %h", i,
                         bus.fetch_fault, bus.instr_valid, bus.imem_addr);
            end
            advance();
        end
        drive(1'b1, 1'b1, 32'h10);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL misaligned recover %0d: got %h want %h", i, obs(), expv());
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seq [4];
        seq[0] = 32'hFFFFFFF8;
        seq[1] = 32'hFFFFFFFC;
        seq[2] = 32'h0;
        seq[3] = 32'h4;
        drive(1'b1, 1'b1, 32'hFFFFFFF8);
        advance();
        drive(1'b1, 1'b0, 32'd0);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            checks++;
            if ({bus.instr_valid, bus.instr_pc, bus.instr_data} !== {1'b1, seq[i], seq[i] ^ KEY}) begin
                errors++;
                $display("FAIL wrap %0d: got pc %h want %h", i, bus.instr_pc, seq[i]);
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 32'h41);
        advance();
        drive(1'b1, 1'b1, 32'h100);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            advance();
        end
        drive(1'b1, 1'b1, 32'h203);
        advance();
        drive(1'b1, 1'b0, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.instr_valid, bus.fetch_fault, bus.imem_addr} !== {1'b0, 1'b0, RESET_PC}) begin
            errors++;
            $display("FAIL async_reset: got valid %b fault %b addr %h", bus.instr_valid,
                     bus.fetch_fault, bus.imem_addr);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL async_restart %0d: got %h want %h", i, obs(), expv());
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        logic        v;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            t = $urandom();
            if ($urandom_range(0, 3) != 0) t = t & 32'hFFFFFFFC;
            v = ($urandom_range(0, 11) == 0);
            drive(1'($urandom_range(0, 2) != 0), v, t);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs(), expv());
            end
            advance();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        rdy    = 1'b0;
        rv     = 1'b0;
        rpc    = 32'd0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_misaligned();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
